// File: rtl/prog_lut.sv
// prog_lut: registered N-input lookup cell whose truth table reloads serially while evaluation keeps running
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid, x           present an N-bit input vector for evaluation
//   y, y_valid            registered table[x] and its 1-cycle valid pulse
//   cfg_start             begin (or restart) a truth-table load
//   cfg_valid, cfg_bit    serial table bits, entry 2^N-1 first
//   cfg_ready, busy       high while a load is in progress
//   cfg_done              1-cycle pulse after the new table is committed
module prog_lut #(
  parameter int N = 3,
  parameter logic [(1<<N)-1:0] INIT = 8'hE2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  output logic         y,
  output logic         y_valid,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         busy
);
  localparam int D = 1 << N;
  localparam logic [N:0] LAST = (N+1)'(D - 1);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [D-1:0] lut, shadow, shifted;
  logic [N:0] count;
  logic xfer, last;
  // a restart outranks a bit arriving in the same cycle
  always_comb begin
    cfg_ready = state == LOAD;
    busy = state == LOAD;
    xfer = cfg_ready && cfg_valid && !cfg_start;
    last = xfer && count == LAST;
    shifted = {shadow[D-2:0], cfg_bit};
    state_nx = cfg_start ? LOAD : last ? RUN : state;
  end
  // the active table changes only on the final bit, so evaluation never sees a partial table
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      lut <= INIT;
      shadow <= '0;
      count <= '0;
      y <= 1'b0;
      y_valid <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state <= state_nx;
      y_valid <= in_valid;
      if (in_valid) y <= lut[x];
      cfg_done <= last;
      if (cfg_start) count <= '0;
      else if (xfer) begin
        count <= count + (N+1)'(1);
        shadow <= shifted;
      end
      if (last) lut <= shifted;
    end
endmodule

// File: tb/tb_prog_lut.sv
// tb_prog_lut: directed bench for prog_lut (N=3 default and N=2) with a queue-based reference model
module tb_prog_lut;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic iv = 1'b0, cs = 1'b0, cv = 1'b0, cb = 1'b0;
  logic [2:0] xv = '0;
  logic y0, yv0, rdy0, done0, busy0;
  logic y1, yv1, rdy1, done1, busy1;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_tbl [2];
  logic m_y [2], m_vld [2], m_done [2], m_load [2];
  bit m_bits [2][$];

  always #5 clk = ~clk;

  prog_lut dut (
    .clk(clk), .reset(reset), .in_valid(iv), .x(xv), .y(y0), .y_valid(yv0),
    .cfg_start(cs), .cfg_valid(cv), .cfg_bit(cb), .cfg_ready(rdy0), .cfg_done(done0), .busy(busy0)
  );

  prog_lut #(.N(2), .INIT(4'h8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv), .x(xv[1:0]), .y(y1), .y_valid(yv1),
    .cfg_start(cs), .cfg_valid(cv), .cfg_bit(cb), .cfg_ready(rdy1), .cfg_done(done1), .busy(busy1)
  );

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tbl[0] = 8'hE2;
    m_tbl[1] = 8'h08;
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 1'b0;
      m_vld[k] = 1'b0;
      m_done[k] = 1'b0;
      m_load[k] = 1'b0;
      m_bits[k].delete();
    end
  endtask

  // one clock edge of the behavioural model: table lookup, then collect bits until the table is full
  task automatic model_step(int k);
    int d = (k == 0) ? 8 : 4;
    int xi = (k == 0) ? int'(xv) : int'(xv[1:0]);
    m_vld[k] = iv;
    if (iv) m_y[k] = m_tbl[k][xi];
    m_done[k] = 1'b0;
    if (m_load[k]) begin
      if (cs) m_bits[k].delete();
      else if (cv) begin
        m_bits[k].push_back(cb);
        if (m_bits[k].size() == d) begin
          for (int i = 0; i < d; i++) m_tbl[k][d-1-i] = m_bits[k][i];
          m_done[k] = 1'b1;
          m_load[k] = 1'b0;
          m_bits[k].delete();
        end
      end
    end else if (cs) begin
      m_load[k] = 1'b1;
      m_bits[k].delete();
    end
  endtask

  task automatic tick(logic i, logic [2:0] xx, logic s, logic v, logic b);
    iv = i; xv = xx; cs = s; cv = v; cb = b;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic send(logic [7:0] val, int nbits);
    for (int i = nbits - 1; i >= 0; i--) tick(1'b0, 3'd0, 1'b0, 1'b1, val[i]);
  endtask

  always @(negedge clk) begin
    chk("y", y0, m_y[0]);
    chk("y_valid", yv0, m_vld[0]);
    chk("busy", busy0, m_load[0]);
    chk("cfg_ready", rdy0, m_load[0]);
    chk("cfg_done", done0, m_done[0]);
    chk("y_n2", y1, m_y[1]);
    chk("y_valid_n2", yv1, m_vld[1]);
    chk("busy_n2", busy1, m_load[1]);
    chk("cfg_ready_n2", rdy1, m_load[1]);
    chk("cfg_done_n2", done1, m_done[1]);
  end

  initial begin
    logic [7:0] e2 = 8'hE2;
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_y", y0, 0);
    chk("rst_y_valid", yv0, 0);
    chk("rst_busy", busy0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // default table 0xE2 over every x
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
      chk("init_lit", y0, e2[i]);
      chk("init_lit_vld", yv0, 1);
      chk("init_n2_lit", y1, (i % 4 == 3) ? 1 : 0);
    end
    // load 0x96 while evaluating x=6 on the old table, then on the commit edge
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 3'd6, 1'b0, 1'b1, 1'b1);
    chk("old_tbl_lit", y0, 1);
    send(8'h96 >> 1, 6);
    tick(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    chk("commit_edge_lit", y0, 1);
    chk("done_lit", done0, 1);
    chk("busy_fall_lit", busy0, 0);
    tick(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("new_tbl_lit", y0, 0);
    chk("done_once_lit", done0, 0);
    tick(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("parity7_lit", y0, 1);
    tick(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("parity3_lit", y0, 0);
    // load 0x00 with a 3-cycle gap after the 4th bit
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    send(8'h00, 4);
    repeat (3) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("gap_busy_lit", busy0, 1);
    send(8'h00, 3);
    chk("gap_not_done_lit", done0, 0);
    send(8'h00, 1);
    chk("gap_done_lit", done0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
      chk("zero_tbl_lit", y0, 0);
    end
    // reset in the middle of a load
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 4);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy_lit", busy0, 0);
    chk("midrst_done_lit", done0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("midrst_init_lit", y0, 1);
    // partial load, restart (with a same-cycle bit that must be dropped), then 0x01
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    send(8'h07, 3);
    tick(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    send(8'h01, 8);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
      chk("restart_lit", y0, (i == 0) ? 1 : 0);
    end
    // same sequence shaped for the 4-entry instance: 0x1 gives y only at x=0
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    send(8'h07, 3);
    tick(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    send(8'h01, 4);
    send(8'h00, 4);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
      chk("restart_n2_lit", y1, (i == 0) ? 1 : 0);
    end
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_lut.md
Name: prog_lut

Overview:
- Parametrised, registered successor to the fixed 3-input sum-of-products exercise block: evaluates any N-input Boolean function from a 2^N-bit truth table.
- Truth table is reloadable at run time over a serial bit-stream handshake.
- Default table 8'hE2 reproduces y = AB + !BC, with x = {a,b,c}.
- Sits as a student-facing configurable logic cell; evaluation continues on the old table while a new one loads.

Parameters:
N, 3, number of function inputs (1..6)
INIT, 8'hE2, reset truth table, 2^N bits; bit i = output for x == i

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  x is presented this cycle
x  input  N  function input vector; x[N-1] is the MSB of the table index
y  output  1  registered function output
y_valid  output  1  y holds a fresh result (1-cycle pulse per in_valid)
cfg_start  input  1  begin a truth-table load
cfg_valid  input  1  cfg_bit is valid this cycle
cfg_bit  input  1  serial table bit, MSB (entry 2^N-1) first
cfg_ready  output  1  block accepts a cfg_bit this cycle
cfg_done  output  1  1-cycle pulse: new table committed
busy  output  1  load in progress

Behaviour:
- Reset (async assert, sync release): active table = INIT, shadow = 0, count = 0, state RUN, y = 0, y_valid = 0, cfg_ready = 0, cfg_done = 0, busy = 0.
- Evaluation is independent of the FSM and runs in every state. On each clk edge, y_valid <= in_valid. If in_valid, y <= table[x]; otherwise y holds its value. Latency is 1 cycle, throughput is 1 per cycle.
- FSM state RUN: busy = 0, cfg_ready = 0. A high cfg_start moves to LOAD with count <= 0. cfg_valid is ignored in RUN.
- FSM state LOAD: busy = 1, cfg_ready = 1. A bit transfers when cfg_valid && cfg_ready. On a transfer, shadow <= {shadow[2^N-2:0], cfg_bit} and count <= count + 1. Gaps in cfg_valid stall the load with no timeout.
- Last bit (count == 2^N-1 on a transfer): table <= {shadow[2^N-2:0], cfg_bit}, cfg_done pulses on the next cycle, and the FSM returns to RUN. cfg_ready drops the cycle after the last bit.
- cfg_start in LOAD restarts the load: count <= 0 and the bits already received are discarded. If cfg_start and a transfer occur in the same cycle, the restart wins and the bit is dropped.
- Commit and in_valid in the same cycle: evaluation uses the pre-commit table. The first in_valid after the commit edge uses the new table.
- Counter width is clog2(2^N)+1 = N+1 bits. The counter never wraps, because the commit happens exactly at 2^N bits.
- Reset mid-load: the partial shadow is discarded, the table returns to INIT, and no cfg_done pulse is produced.
- The table is never partially updated; the commit is atomic.

Test Plan:
1. After reset with defaults, apply x = 000..111 with in_valid each cycle -> y one cycle later = 0,1,0,0,0,1,1,1 and y_valid = 1 on each. Check y = 0 and y_valid = 0 during reset.
2. Pulse cfg_start, then stream 0x96 MSB-first (1,0,0,1,0,1,1,0) on consecutive cycles -> cfg_done pulses once and busy falls. Then x = 111 -> y = 1 and x = 011 -> y = 0 (3-input parity).
3. During that load, apply x = 110 -> y = 1 (old table 0xE2). Apply x = 110 with in_valid on the commit cycle -> y = 1. Apply x = 110 on the next cycle -> y = 0 (new table).
4. Load 0x00 with cfg_valid deasserted for 3 cycles between bits 4 and 5 -> the count stalls, and cfg_done arrives only after the 8th accepted bit. Then every x -> y = 0.
5. Send 4 bits of 0xFF, then assert reset -> busy = 0, no cfg_done pulse, and x = 001 -> y = 1 (INIT restored).
6. Send 3 bits, pulse cfg_start, then send 0x01 -> only x = 000 gives y = 1. Repeat with N = 2, INIT = 4'h8 -> y = x[1] & x[0].
